// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that
// produces packed BCD digits, per-digit leading-zero display flags and saturation on overflow.
module bin_to_bcd_seq #(
    parameter int BIN_WIDTH = 14,
    parameter int DIGITS    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     first,
    output logic                  overflow
);

    // Scratch holds every digit the input width can reach, so the add-3 pass never truncates.
    localparam int SN = (DIGITS > (BIN_WIDTH + 2) / 3) ? DIGITS : (BIN_WIDTH + 2) / 3;
    localparam int SW = 4 * SN;
    localparam int CW = $clog2(BIN_WIDTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    function automatic logic [63:0] max_value();
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < DIGITS; i++) v = v * 64'd10;
        return v - 64'd1;
    endfunction

    localparam logic [63:0] MAXV = max_value();

    function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        r = s;
        for (int i = 0; i < SN; i++)
            if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
        return r;
    endfunction

    function automatic logic [4*DIGITS-1:0] all_nines();
        logic [4*DIGITS-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'd9;
        return r;
    endfunction

    // A digit is shown when it or any more significant digit is nonzero; digit 0 always shows.
    function automatic logic [DIGITS-1:0] first_flags(input logic [4*DIGITS-1:0] d);
        logic [DIGITS-1:0] f;
        logic              any;
        any = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            any  = any | (d[4*i +: 4] != 4'd0);
            f[i] = any | (i == 0);
        end
        return f;
    endfunction

    logic [0:0]           state;
    logic [BIN_WIDTH-1:0] binreg;
    logic [SW-1:0]        scratch;
    logic [CW-1:0]        cnt;
    logic                 ovf_lat;

    logic [SW-1:0]        adj;
    logic [SW-1:0]        nxt_scratch;
    logic [4*DIGITS-1:0]  nxt_bcd;

    always_comb begin
        adj         = add3(scratch);
        nxt_scratch = (adj << 1) | SW'(binreg[BIN_WIDTH-1]);
        nxt_bcd     = ovf_lat ? all_nines() : nxt_scratch[4*DIGITS-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            first    <= DIGITS'(1);
            overflow <= 1'b0;
            binreg   <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_lat  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        binreg  <= bin;
                        scratch <= '0;
                        cnt     <= CW'(BIN_WIDTH);
                        ovf_lat <= (64'(bin) > MAXV);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= nxt_scratch;
                    binreg  <= binreg << 1;
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd      <= nxt_bcd;
                        first    <= ovf_lat ? {DIGITS{1'b1}} : first_flags(nxt_bcd);
                        overflow <= ovf_lat;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus queues expected results, a
// monitor checks each done pulse against the queue head, including its cycle.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] bin;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic [3:0]  first;
    logic        overflow;

    bin_to_bcd_seq #(.BIN_WIDTH(14), .DIGITS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .first(first), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  first;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            chk("done_has_request", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("bcd", bcd, e.bcd);
                chk("first", first, e.first);
                chk("overflow", overflow, e.ovf);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic [13:0] b, input logic [15:0] ebcd,
                         input logic [3:0] efirst, input logic eovf);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle_wait", busy, 0);
        start = 1'b1;
        bin   = b;
        @(posedge clk);
        #1;
        sb.push_back('{ebcd, efirst, eovf, cyc + 14});
        start = 1'b0;
        bin   = 14'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic chk_reset_values();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd, 16'h0000);
        chk("rst_first", first, 4'b0001);
        chk("rst_overflow", overflow, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic busy_ok;
        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        chk_reset_values();
        reset = 1'b0;

        // Zero conversion with busy profile check
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd0;
        @(posedge clk);
        #1;
        sb.push_back('{16'h0000, 4'b0001, 1'b0, cyc + 14});
        start   = 1'b0;
        busy_ok = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            busy_ok = busy_ok & busy;
        end
        chk("busy_during", busy_ok, 1);
        @(negedge clk);
        chk("busy_after", busy, 0);

        issue(14'd1234,  16'h1234, 4'b1111, 1'b0);
        issue(14'd907,   16'h0907, 4'b0111, 1'b0);
        issue(14'd9999,  16'h9999, 4'b1111, 1'b0);
        issue(14'd12000, 16'h9999, 4'b1111, 1'b1);
        issue(14'd10000, 16'h9999, 4'b1111, 1'b1);
        issue(14'd16383, 16'h9999, 4'b1111, 1'b1);
        issue(14'd100,   16'h0100, 4'b0111, 1'b0);
        issue(14'd5,     16'h0005, 4'b0001, 1'b0);
        drain();

        // start during busy is ignored
        issue(14'd42, 16'h0042, 4'b0011, 1'b0);
        repeat (5) begin
            @(negedge clk);
            start = 1'b1;
            bin   = 14'd55;
        end
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (20) @(negedge clk);
        chk("no_extra_done", sb.size(), 0);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd7;
        @(posedge clk);
        #1;
        sb.push_back('{16'h0007, 4'b0001, 1'b0, cyc + 14});
        bin = 14'd8;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!done && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) chk("b2b_first_done", done, 1);
        end
        @(posedge clk);
        #1;
        sb.push_back('{16'h0008, 4'b0001, 1'b0, cyc + 14});
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bcd_hold", bcd, 16'h0007);
        end
        drain();

        // Reset in the middle of a conversion
        @(negedge clk);
        start = 1'b1;
        bin   = 14'd321;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_values();
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        issue(14'd321, 16'h0321, 4'b0111, 1'b0);
        drain();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
